// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
// Stall, bubble and forwarding control for a 5-stage pipeline with a
// variable-latency data memory. Define FORWARDING_EN to enable operand
// forwarding (load-use stall only); without it every RAW dependency on an
// in-flight write stalls decode until the producer has retired.
module pipeline_hazard_controller #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [4:0]             d_rs,
  input  logic [4:0]             d_rt,
  input  logic                   d_uses_rs,
  input  logic                   d_uses_rt,
  input  logic                   e_register_write,
  input  logic                   e_memory_to_register,
  input  logic [4:0]             e_register_destination,
  input  logic                   m_register_write,
  input  logic                   m_memory_to_register,
  input  logic                   m_memory_write,
  input  logic [4:0]             m_register_destination,
  input  logic                   w_register_write,
  input  logic [4:0]             w_register_destination,
  input  logic                   mem_ready,
  output logic                   pc_write,
  output logic                   fd_write,
  output logic                   de_write,
  output logic                   em_write,
  output logic                   de_bubble,
  output logic                   mw_bubble,
  output logic [1:0]             forward_a,
  output logic [1:0]             forward_b,
  output logic                   mem_error,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MEM_WAIT = 1'b1;

  logic [0:0]             state_q, state_d;
  logic [7:0]             wait_q, wait_d;
  logic                   err_q, err_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  logic pc_en, fd_en, de_en, em_en, de_bub, mw_bub;
  logic hazard, mem_access;
  logic [1:0] fwd_a, fwd_b;
  logic e_rs, e_rt, m_rs, m_rt, w_rs, w_rt;

  function automatic logic reg_match(input logic wr, input logic [4:0] dst,
                                     input logic [4:0] src, input logic uses);
    return uses && wr && (dst != 5'd0) && (dst == src);
  endfunction

  assign e_rs = reg_match(e_register_write, e_register_destination, d_rs, d_uses_rs);
  assign e_rt = reg_match(e_register_write, e_register_destination, d_rt, d_uses_rt);
  assign m_rs = reg_match(m_register_write, m_register_destination, d_rs, d_uses_rs);
  assign m_rt = reg_match(m_register_write, m_register_destination, d_rt, d_uses_rt);
  assign w_rs = reg_match(w_register_write, w_register_destination, d_rs, d_uses_rs);
  assign w_rt = reg_match(w_register_write, w_register_destination, d_rt, d_uses_rt);

  assign mem_access = m_memory_to_register | m_memory_write;

`ifdef FORWARDING_EN
  // Only a load in execute cannot be bypassed; memory stage wins over writeback.
  assign hazard = e_memory_to_register & (e_rs | e_rt);
  assign fwd_a  = m_rs ? 2'b10 : (w_rs ? 2'b01 : 2'b00);
  assign fwd_b  = m_rt ? 2'b10 : (w_rt ? 2'b01 : 2'b00);
`else
  logic unused_e_mtr;
  assign unused_e_mtr = e_memory_to_register;
  assign hazard = e_rs | e_rt | m_rs | m_rt | w_rs | w_rt;
  assign fwd_a  = 2'b00;
  assign fwd_b  = 2'b00;
`endif

  // Stall/bubble decision and FSM/counter next state.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = err_q;
    pc_en   = 1'b1;
    fd_en   = 1'b1;
    de_en   = 1'b1;
    em_en   = 1'b1;
    de_bub  = 1'b0;
    mw_bub  = 1'b0;
    if (state_q == RUN) begin
      if (mem_access && !mem_ready) begin
        {pc_en, fd_en, de_en, em_en} = 4'b0000;
        mw_bub  = 1'b1;
        state_d = MEM_WAIT;
        wait_d  = '0;
      end else if (hazard) begin
        pc_en  = 1'b0;
        fd_en  = 1'b0;
        de_bub = 1'b1;
      end
    end else begin
      if (mem_ready) begin
        state_d = RUN;
      end else if (wait_q == 8'(MEM_TIMEOUT)) begin
        state_d = RUN;
        err_d   = 1'b1;
      end else begin
        {pc_en, fd_en, de_en, em_en} = 4'b0000;
        mw_bub = 1'b1;
        wait_d = wait_q + 8'd1;
      end
    end
    stall_d = (!pc_en && (stall_q != '1)) ? stall_q + STALL_CNT_W'(1) : stall_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      stall_q <= stall_d;
    end
  end

  // Outputs are forced low for the whole reset cycle, including the
  // registered flags whose clear only lands at the next edge.
  assign pc_write    = pc_en  & ~reset;
  assign fd_write    = fd_en  & ~reset;
  assign de_write    = de_en  & ~reset;
  assign em_write    = em_en  & ~reset;
  assign de_bubble   = de_bub & ~reset;
  assign mw_bubble   = mw_bub & ~reset;
  assign forward_a   = reset ? 2'b00 : fwd_a;
  assign forward_b   = reset ? 2'b00 : fwd_b;
  assign mem_error   = err_q & ~reset;
  assign stall_count = reset ? '0 : stall_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller. Follows FORWARDING_EN.
module tb_pipeline_hazard_controller;

  localparam int unsigned TMO  = 4;
  localparam int unsigned SCW  = 4;
  localparam int unsigned SMAX = (1 << SCW) - 1;
`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  logic [4:0] d_rs, d_rt, e_register_destination, m_register_destination, w_register_destination;
  logic d_uses_rs, d_uses_rt, e_register_write, e_memory_to_register;
  logic m_register_write, m_memory_to_register, m_memory_write, w_register_write, mem_ready;
  logic pc_write, fd_write, de_write, em_write, de_bubble, mw_bubble, mem_error;
  logic [1:0] forward_a, forward_b;
  logic [SCW-1:0] stall_count;

  pipeline_hazard_controller #(.MEM_TIMEOUT(TMO), .STALL_CNT_W(SCW)) dut (
    .clock(clock), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt), .d_uses_rs(d_uses_rs), .d_uses_rt(d_uses_rt),
    .e_register_write(e_register_write), .e_memory_to_register(e_memory_to_register),
    .e_register_destination(e_register_destination),
    .m_register_write(m_register_write), .m_memory_to_register(m_memory_to_register),
    .m_memory_write(m_memory_write), .m_register_destination(m_register_destination),
    .w_register_write(w_register_write), .w_register_destination(w_register_destination),
    .mem_ready(mem_ready),
    .pc_write(pc_write), .fd_write(fd_write), .de_write(de_write), .em_write(em_write),
    .de_bubble(de_bubble), .mw_bubble(mw_bubble),
    .forward_a(forward_a), .forward_b(forward_b),
    .mem_error(mem_error), .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  int nvec  = 0;
  int nfail = 0;

  // Reference model: abstract "waiting on memory" flag, cycles waited, sticky error, stall total.
  bit          mdl_wait;
  int unsigned mdl_waited;
  bit          mdl_err;
  int unsigned mdl_stalls;

  // {pc,fd,de,em,de_bubble,mw_bubble,fwd_a,fwd_b,mem_error,stall_count}
  logic [14:0] exp_v, act_v;

  // Stage 0 = execute, 1 = memory, 2 = writeback.
  function automatic bit src_match(int stage, logic [4:0] r, logic uses);
    logic wr;
    logic [4:0] dst;
    case (stage)
      0:       begin wr = e_register_write; dst = e_register_destination; end
      1:       begin wr = m_register_write; dst = m_register_destination; end
      default: begin wr = w_register_write; dst = w_register_destination; end
    endcase
    return uses && wr && (dst != 5'd0) && (dst == r);
  endfunction

  function automatic logic [1:0] fwd_for(logic [4:0] r, logic uses);
    if (!FWD) return 2'b00;
    if (src_match(1, r, uses)) return 2'b10;
    if (src_match(2, r, uses)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit hazard_for(logic [4:0] r, logic uses);
    bit any_stage;
    bit load_use;
    any_stage = src_match(0, r, uses) || src_match(1, r, uses) || src_match(2, r, uses);
    load_use  = src_match(0, r, uses) && e_memory_to_register;
    return FWD ? load_use : any_stage;
  endfunction

  task automatic clear_inputs();
    reset = 1'b0;
    d_rs = '0; d_rt = '0; d_uses_rs = 1'b0; d_uses_rt = 1'b0;
    e_register_write = 1'b0; e_memory_to_register = 1'b0; e_register_destination = '0;
    m_register_write = 1'b0; m_memory_to_register = 1'b0; m_memory_write = 1'b0;
    m_register_destination = '0;
    w_register_write = 1'b0; w_register_destination = '0;
    mem_ready = 1'b1;
  endtask

  task automatic rand_inputs();
    d_rs = 5'($urandom_range(0, 3));
    d_rt = 5'($urandom_range(0, 3));
    d_uses_rs = 1'($urandom_range(0, 1));
    d_uses_rt = 1'($urandom_range(0, 1));
    e_register_write = 1'($urandom_range(0, 1));
    e_memory_to_register = ($urandom_range(0, 3) == 0);
    e_register_destination = 5'($urandom_range(0, 3));
    m_register_write = 1'($urandom_range(0, 1));
    m_memory_to_register = ($urandom_range(0, 4) == 0);
    m_memory_write = ($urandom_range(0, 5) == 0);
    m_register_destination = 5'($urandom_range(0, 3));
    w_register_write = 1'($urandom_range(0, 1));
    w_register_destination = 5'($urandom_range(0, 3));
    mem_ready = ($urandom_range(0, 9) < 7);
    reset = ($urandom_range(0, 49) == 0);
  endtask

  // Inputs are set just after a falling edge; expected outputs are formed from
  // the model, outputs sampled 1ns later, then the model advances at the rising edge.
  task automatic tick();
    bit frz, tmo, enter;
    logic pc, fd, de, em, deb, mwb;
    #1;
    frz = 1'b0; tmo = 1'b0; enter = 1'b0;
    {pc, fd, de, em, deb, mwb} = 6'b111100;
    if (reset) begin
      {pc, fd, de, em, deb, mwb} = 6'b000000;
    end else if (mdl_wait) begin
      if (!mem_ready) begin
        if (mdl_waited < TMO) frz = 1'b1;
        else tmo = 1'b1;
      end
    end else if ((m_memory_to_register || m_memory_write) && !mem_ready) begin
      frz = 1'b1;
      enter = 1'b1;
    end else if (hazard_for(d_rs, d_uses_rs) || hazard_for(d_rt, d_uses_rt)) begin
      pc = 1'b0; fd = 1'b0; deb = 1'b1;
    end
    if (frz) {pc, fd, de, em, deb, mwb} = 6'b000001;
    exp_v = {pc, fd, de, em, deb, mwb,
             reset ? 2'b00 : fwd_for(d_rs, d_uses_rs),
             reset ? 2'b00 : fwd_for(d_rt, d_uses_rt),
             reset ? 1'b0 : mdl_err,
             reset ? SCW'(0) : SCW'(mdl_stalls)};
    act_v = {pc_write, fd_write, de_write, em_write, de_bubble, mw_bubble,
             forward_a, forward_b, mem_error, stall_count};
    @(posedge clock);
    if (reset) begin
      mdl_wait = 1'b0; mdl_waited = 0; mdl_err = 1'b0; mdl_stalls = 0;
    end else begin
      if (!pc && mdl_stalls < SMAX) mdl_stalls++;
      if (tmo) mdl_err = 1'b1;
      if (enter) begin
        mdl_wait = 1'b1;
        mdl_waited = 0;
      end else if (mdl_wait) begin
        if (frz) mdl_waited++;
        else mdl_wait = 1'b0;
      end
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    d_rs = 5'd3; d_uses_rs = 1'b1; m_register_write = 1'b1; m_register_destination = 5'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      nvec++;
      if (act_v !== exp_v) begin
        nfail++;
        $display("FAIL reset[%0d]: got %h expected %h", i, act_v, exp_v);
      end
      nvec++;
      if (act_v !== 15'h0) begin
        nfail++;
        $display("FAIL reset_zero[%0d]: got %h expected 0", i, act_v);
      end
    end
    clear_inputs();
  endtask

  task automatic test_load_use_forwarding();
    int stalls = 0;
    clear_inputs();
    // lw $8 in execute, add reading $8 in decode
    e_register_write = 1'b1; e_memory_to_register = 1'b1; e_register_destination = 5'd8;
    d_rs = 5'd8; d_uses_rs = 1'b1;
    tick();
    nvec++;
    if (act_v !== exp_v) begin nfail++; $display("FAIL load_use_c1: got %h expected %h", act_v, exp_v); end
    if (act_v[14] == 1'b0) stalls++;
    // load now in writeback
    e_register_write = 1'b0; e_memory_to_register = 1'b0; e_register_destination = '0;
    w_register_write = 1'b1; w_register_destination = 5'd8;
    tick();
    nvec++;
    if (act_v !== exp_v) begin nfail++; $display("FAIL load_use_c2: got %h expected %h", act_v, exp_v); end
    if (act_v[14] == 1'b0) stalls++;
    nvec++;
    if (stalls !== (FWD ? 1 : 2)) begin
      nfail++;
      $display("FAIL load_use_stalls: got %0d expected %0d", stalls, FWD ? 1 : 2);
    end
    nvec++;
    if (act_v[8:7] !== (FWD ? 2'b01 : 2'b00)) begin
      nfail++;
      $display("FAIL load_use_fwd_a: got %b expected %b", act_v[8:7], FWD ? 2'b01 : 2'b00);
    end
    // memory and writeback both write $5, decode reads rt=5
    clear_inputs();
    m_register_write = 1'b1; m_register_destination = 5'd5;
    w_register_write = 1'b1; w_register_destination = 5'd5;
    d_rt = 5'd5; d_uses_rt = 1'b1;
    tick();
    nvec++;
    if (act_v !== exp_v) begin nfail++; $display("FAIL fwd_priority: got %h expected %h", act_v, exp_v); end
    nvec++;
    if (act_v[6:5] !== (FWD ? 2'b10 : 2'b00)) begin
      nfail++;
      $display("FAIL fwd_b_mem: got %b expected %b", act_v[6:5], FWD ? 2'b10 : 2'b00);
    end
    // register zero never matches
    e_register_write = 1'b1; e_memory_to_register = 1'b1;
    m_register_destination = '0; w_register_destination = '0; d_rt = '0; d_rs = '0;
    d_uses_rs = 1'b1;
    tick();
    nvec++;
    if (act_v[14:5] !== 10'b1111000000) begin
      nfail++;
      $display("FAIL reg_zero: got %b expected 1111000000", act_v[14:5]);
    end
    clear_inputs();
  endtask

  task automatic test_dependency_chain();
    int stalls = 0;
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    // add $9 walks e -> m -> w while decode keeps reading rs=9
    d_rs = 5'd9; d_uses_rs = 1'b1;
    for (int s = 0; s < 4; s++) begin
      e_register_write = (s == 0); e_register_destination = (s == 0) ? 5'd9 : 5'd0;
      m_register_write = (s == 1); m_register_destination = (s == 1) ? 5'd9 : 5'd0;
      w_register_write = (s == 2); w_register_destination = (s == 2) ? 5'd9 : 5'd0;
      tick();
      nvec++;
      if (act_v !== exp_v) begin nfail++; $display("FAIL chain[%0d]: got %h expected %h", s, act_v, exp_v); end
      if (act_v[14] == 1'b0) stalls++;
    end
    nvec++;
    if (stalls !== (FWD ? 0 : 3)) begin
      nfail++;
      $display("FAIL chain_stalls: got %0d expected %0d", stalls, FWD ? 0 : 3);
    end
    nvec++;
    if (act_v[3:0] !== SCW'(FWD ? 0 : 3)) begin
      nfail++;
      $display("FAIL chain_count: got %0d expected %0d", act_v[3:0], FWD ? 0 : 3);
    end
    clear_inputs();
  endtask

  task automatic test_mem_wait();
    int frozen = 0;
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_memory_write = 1'b1; mem_ready = 1'b0;
    e_register_write = 1'b1; e_memory_to_register = 1'b1; e_register_destination = 5'd8;
    d_rs = 5'd8; d_uses_rs = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mem_ready = (i == 4);
      tick();
      nvec++;
      if (act_v !== exp_v) begin nfail++; $display("FAIL mem_wait[%0d]: got %h expected %h", i, act_v, exp_v); end
      if (act_v[14:9] == 6'b000001) frozen++;
    end
    nvec++;
    if (frozen !== 4) begin nfail++; $display("FAIL mem_wait_frozen: got %0d expected 4", frozen); end
    nvec++;
    if (act_v[14:9] !== 6'b111100) begin
      nfail++;
      $display("FAIL mem_release: got %b expected 111100", act_v[14:9]);
    end
    clear_inputs();
  endtask

  task automatic test_timeout_and_reset();
    int frozen = 0;
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_memory_to_register = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < TMO + 2; i++) begin
      tick();
      nvec++;
      if (act_v !== exp_v) begin nfail++; $display("FAIL timeout[%0d]: got %h expected %h", i, act_v, exp_v); end
      if (act_v[14] == 1'b0) frozen++;
    end
    nvec++;
    if (frozen !== TMO + 1 || act_v[14:11] !== 4'hF) begin
      nfail++;
      $display("FAIL timeout_release: got %0d frozen, enables %b expected %0d, 1111", frozen, act_v[14:11], TMO + 1);
    end
    // back in RUN with the access still pending: freezes again, error now visible
    tick();
    nvec++;
    if (act_v[4] !== 1'b1 || act_v[14:9] !== 6'b000001) begin
      nfail++;
      $display("FAIL timeout_error: got err=%b ctl=%b expected err=1 ctl=000001", act_v[4], act_v[14:9]);
    end
    // reset in the middle of the wait
    reset = 1'b1;
    tick();
    nvec++;
    if (act_v !== 15'h0) begin nfail++; $display("FAIL reset_mid_wait: got %h expected 0", act_v); end
    // first cycle after reset is RUN: a load-use hazard bubbles
    clear_inputs();
    e_register_write = 1'b1; e_memory_to_register = 1'b1; e_register_destination = 5'd2;
    d_rs = 5'd2; d_uses_rs = 1'b1;
    tick();
    nvec++;
    if (act_v !== exp_v) begin nfail++; $display("FAIL after_reset: got %h expected %h", act_v, exp_v); end
    nvec++;
    if (act_v[14:9] !== 6'b001110 || act_v[4:0] !== 5'h0) begin
      nfail++;
      $display("FAIL after_reset_run: got ctl=%b err/cnt=%h expected 001110, 00", act_v[14:9], act_v[4:0]);
    end
    clear_inputs();
  endtask

  task automatic test_saturation();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    e_register_write = 1'b1; e_memory_to_register = 1'b1; e_register_destination = 5'd3;
    d_rs = 5'd3; d_uses_rs = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      nvec++;
      if (act_v !== exp_v) begin nfail++; $display("FAIL saturate[%0d]: got %h expected %h", i, act_v, exp_v); end
    end
    nvec++;
    if (act_v[3:0] !== SCW'(SMAX)) begin
      nfail++;
      $display("FAIL saturate_final: got %0d expected %0d", act_v[3:0], SMAX);
    end
    clear_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      tick();
      nvec++;
      if (act_v !== exp_v) begin nfail++; $display("FAIL random[%0d]: got %h expected %h", i, act_v, exp_v); end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    mdl_wait = 1'b0; mdl_waited = 0; mdl_err = 1'b0; mdl_stalls = 0;
    @(negedge clock);
    test_reset();
    test_load_use_forwarding();
    test_dependency_chain();
    test_mem_wait();
    test_timeout_and_reset();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 16, giving the maximum number of memory wait cycles before an error is flagged (range 2..255).
REQ-002 The block SHALL have parameter STALL_CNT_W, default 16, giving the width of the stall performance counter.
REQ-003 Port clock  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port reset  in  1  synchronous, active-high reset.
REQ-005 Ports d_rs, d_rt  in  5 each  source registers of the instruction in decode.
REQ-006 Ports d_uses_rs, d_uses_rt  in  1 each  the decode instruction reads that source.
REQ-007 Ports e_register_write, e_memory_to_register  in  1 each; e_register_destination  in  5  execute-stage controls.
REQ-008 Ports m_register_write, m_memory_to_register, m_memory_write  in  1 each; m_register_destination  in  5  memory-stage controls.
REQ-009 Ports w_register_write  in  1; w_register_destination  in  5  writeback-stage controls.
REQ-010 Port mem_ready  in  1  data memory has completed the current memory-stage access.
REQ-011 Ports pc_write, fd_write, de_write, em_write  out  1 each  enable for the PC and for each pipeline register.
REQ-012 Ports de_bubble, mw_bubble  out  1 each  load a NOP (all control bits 0) into D/E or M/W.
REQ-013 Ports forward_a, forward_b  out  2 each  execute operand source select: 00 register file, 01 writeback, 10 memory stage.
REQ-014 Ports mem_error  out  1 (sticky timeout flag); stall_count  out  STALL_CNT_W (saturating stall-cycle count).

Function
REQ-015 The FSM SHALL have two states, RUN and MEM_WAIT.
REQ-016 A memory access SHALL be defined as m_memory_to_register OR m_memory_write.
REQ-017 In RUN, a memory access with mem_ready=0 SHALL, in the same cycle, drive pc_write=fd_write=de_write=em_write=0 and mw_bubble=1, and SHALL move the FSM to MEM_WAIT.
REQ-018 In MEM_WAIT, the outputs of REQ-017 SHALL hold until mem_ready=1. In that cycle all enables SHALL be 1, mw_bubble SHALL be 0, and the FSM SHALL return to RUN.
REQ-019 An internal wait counter SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle. When it reaches MEM_TIMEOUT with mem_ready still 0, mem_error SHALL set, the FSM SHALL return to RUN, and enables SHALL be released for that cycle.
REQ-020 A register match SHALL require an equal, nonzero destination, a set stage register_write, and the corresponding d_uses_* bit.
REQ-021 A data hazard in RUN (REQ-030/REQ-031) with no memory stall SHALL drive pc_write=fd_write=0 and de_bubble=1, with em_write=de_write=1, for that cycle only. The condition SHALL be re-evaluated every cycle.
REQ-022 A memory stall SHALL take priority over a data hazard; de_bubble SHALL be 0 while frozen.
REQ-023 With no stall and no hazard, all enables SHALL be 1 and both bubbles SHALL be 0.
REQ-024 stall_count SHALL increment by 1 in every cycle where pc_write=0, and SHALL saturate at all-ones (no wrap).
REQ-025 mem_error SHALL remain set until reset; it SHALL NOT block further operation.

Reset
REQ-026 While reset=1, the FSM SHALL be RUN, the wait counter SHALL be 0, stall_count SHALL be 0 and mem_error SHALL be 0.
REQ-027 While reset=1, all enables, bubbles and forward_a/forward_b SHALL be 0.
REQ-028 Reset asserted in MEM_WAIT SHALL abort the wait; the first cycle after reset SHALL be RUN.

Configuration
REQ-029 Macro FORWARDING_EN SHALL select forwarding.
REQ-030 With FORWARDING_EN defined:
- forward_a/forward_b SHALL be 10 on a memory-stage match, else 01 on a writeback match, else 00; the memory stage SHALL win when both match.
- A hazard SHALL exist only on an execute-stage match with e_memory_to_register=1 (one-cycle load-use stall).
REQ-031 With FORWARDING_EN undefined:
- forward_a/forward_b SHALL be tied to 00.
- A hazard SHALL exist on any execute-, memory- or writeback-stage match, giving up to 3 stall cycles.

Verification
REQ-032 FORWARDING_EN on; e: lw $8 (e_memory_to_register=1, dest 8); d: add, rs=8 -> exactly 1 cycle of pc_write=0, de_bubble=1; next cycle forward_a=01.
REQ-033 FORWARDING_EN on; m: dest 5 write; w: dest 5 write; d: rt=5 -> forward_b=10, no stall; destination 0 in all stages -> forward 00, no stall.
REQ-034 FORWARDING_EN off; add dest 9 followed by dependent rs=9 -> 3 consecutive stall cycles; stall_count increases by 3.
REQ-035 m_memory_write=1, mem_ready low for 4 cycles -> all enables 0 and mw_bubble=1 for 4 cycles; release on the 5th cycle; a simultaneous load-use hazard is held, not bubbled, during the wait.
REQ-036 MEM_TIMEOUT=4, mem_ready stuck 0 -> mem_error=1 after 4 wait cycles, FSM back in RUN.
REQ-037 mem_error=1, then reset=1 mid-MEM_WAIT -> mem_error=0, stall_count=0, outputs 0; the cycle after reset is in RUN.
